// File: rtl/matrix_mult_pkg.sv
// ============================================================================
// Package  : matrix_mult_pkg
// Desc     : Shared widths, FSM encoding and element helpers for matrix_mult_seq.
// Revision : 1.0
// ============================================================================
`default_nettype none

package matrix_mult_pkg;

  localparam int MM_DW = 4;
  localparam int MM_CW = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRIVE = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  // Result element order; also the {i,j} row/column pair of each element.
  localparam logic [1:0] E00 = 2'd0;
  localparam logic [1:0] E01 = 2'd1;
  localparam logic [1:0] E10 = 2'd2;
  localparam logic [1:0] E11 = 2'd3;

  function automatic logic [MM_DW-1:0] elem(input logic [4*MM_DW-1:0] mat,
                                            input logic i,
                                            input logic j);
    return mat[int'({i, j})*MM_DW +: MM_DW];
  endfunction

endpackage

`default_nettype wire

// File: rtl/matrix_mult_ref_dot.sv
// ============================================================================
// Module   : matrix_mult_ref_dot
// Desc     : Combinational reference dot product, built only when
//            MATRIX_MULT_SEQ_CHECK_EN is defined.
// Revision : 1.0
// ============================================================================
`default_nettype none

`ifdef MATRIX_MULT_SEQ_CHECK_EN
module matrix_mult_ref_dot #(
  parameter int DW = 4,
  parameter int CW = 8
) (
  input  logic [DW-1:0] i_a0,
  input  logic [DW-1:0] i_a1,
  input  logic [DW-1:0] i_b0,
  input  logic [DW-1:0] i_b1,
  output logic [CW-1:0] o_c
);

  // Work at the wider of the exact sum and CW, then keep the low CW bits.
  localparam int PW = 2*DW + 1;
  localparam int XW = (PW > CW) ? PW : CW;

  logic [XW-1:0] w_sum;

  assign w_sum = XW'(i_a0) * XW'(i_b0) + XW'(i_a1) * XW'(i_b1);
  assign o_c   = w_sum[CW-1:0];

endmodule
`endif

`default_nettype wire

// File: rtl/matrix_mult_seq.sv
// ============================================================================
// Module   : matrix_mult_seq
// Desc     : Sequencer that feeds a 2-element dot-product unit four times to
//            form C = A*B (2x2). Optional self-check: MATRIX_MULT_SEQ_CHECK_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none

module matrix_mult_seq
  import matrix_mult_pkg::*;
#(
  parameter int DW       = MM_DW,
  parameter int CW       = MM_CW,
  parameter int PIPE_LAT = 0
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [4*DW-1:0] a_mat,
  input  logic [4*DW-1:0] b_mat,
  output logic [DW-1:0] mm_a0,
  output logic [DW-1:0] mm_a1,
  output logic [DW-1:0] mm_b0,
  output logic [DW-1:0] mm_b1,
  input  logic [CW-1:0] mm_c,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [4*CW-1:0] c_mat,
  output logic          busy,
  output logic          err
);

  localparam int LW = (PIPE_LAT > 0) ? $clog2(PIPE_LAT + 1) : 1;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [1:0]      r_idx;
  logic [LW-1:0]   r_lat;
  logic [4*DW-1:0] r_a;
  logic [4*DW-1:0] r_b;
  logic [4*CW-1:0] r_c;

  logic            w_in_ready;
  logic            w_out_valid;
  logic            w_busy;
  logic            w_accept;
  logic            w_capture;
  logic [DW-1:0]   w_a0;
  logic [DW-1:0]   w_a1;
  logic [DW-1:0]   w_b0;
  logic [DW-1:0]   w_b1;

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_in_ready  = 1'b0;
    w_out_valid = 1'b0;
    w_busy      = 1'b0;
    w_accept    = 1'b0;
    w_capture   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_in_ready = 1'b1;
        if (in_valid) begin
          w_accept    = 1'b1;
          w_state_nxt = ST_DRIVE;
        end
      end
      ST_DRIVE: begin
        w_busy = 1'b1;
        if (r_lat == LW'(PIPE_LAT)) begin
          w_capture = 1'b1;
          if (r_idx == E11) begin
            w_state_nxt = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        w_out_valid = 1'b1;
        if (out_ready) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_a   <= '0;
      r_b   <= '0;
      r_c   <= '0;
      r_idx <= E00;
      r_lat <= '0;
    end else if (w_accept) begin
      r_a   <= a_mat;
      r_b   <= b_mat;
      r_idx <= E00;
      r_lat <= '0;
    end else if (w_capture) begin
      r_c[int'(r_idx)*CW +: CW] <= mm_c;
      r_idx <= r_idx + 2'd1;
      r_lat <= '0;
    end else if (w_busy) begin
      r_lat <= r_lat + LW'(1);
    end
  end

  // Element (i,j) = r_idx: row i of A against column j of B.
  generate
    if (DW == MM_DW) begin : g_elem_pkg
      assign w_a0 = elem(r_a, r_idx[1], 1'b0);
      assign w_a1 = elem(r_a, r_idx[1], 1'b1);
      assign w_b0 = elem(r_b, 1'b0, r_idx[0]);
      assign w_b1 = elem(r_b, 1'b1, r_idx[0]);
    end else begin : g_elem_generic
      assign w_a0 = r_a[int'({r_idx[1], 1'b0})*DW +: DW];
      assign w_a1 = r_a[int'({r_idx[1], 1'b1})*DW +: DW];
      assign w_b0 = r_b[int'({1'b0, r_idx[0]})*DW +: DW];
      assign w_b1 = r_b[int'({1'b1, r_idx[0]})*DW +: DW];
    end
  endgenerate

  assign mm_a0 = w_busy ? w_a0 : '0;
  assign mm_a1 = w_busy ? w_a1 : '0;
  assign mm_b0 = w_busy ? w_b0 : '0;
  assign mm_b1 = w_busy ? w_b1 : '0;

  // Held low while RST is asserted so ready first appears after release.
  assign in_ready  = w_in_ready & ~RST;
  assign out_valid = w_out_valid;
  assign busy      = w_busy;
  assign c_mat     = r_c;

`ifdef MATRIX_MULT_SEQ_CHECK_EN
  logic [CW-1:0] w_ref_c;
  logic          r_err;

  matrix_mult_ref_dot #(
    .DW (DW),
    .CW (CW)
  ) u_ref_dot (
    .i_a0 (w_a0),
    .i_a1 (w_a1),
    .i_b0 (w_b0),
    .i_b1 (w_b1),
    .o_c  (w_ref_c)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_err <= 1'b0;
    end else if (w_capture && (mm_c != w_ref_c)) begin
      r_err <= 1'b1;
    end
  end

  assign err = r_err;
`else
  assign err = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_matrix_mult_seq.sv
// ============================================================================
// Module   : tb_matrix_mult_seq
// Desc     : Bench for matrix_mult_seq with PIPE_LAT=0 and PIPE_LAT=2 instances,
//            each driving its own behavioural dot-product unit.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_matrix_mult_seq;

  logic        clk = 1'b0;
  logic        rst [2];
  logic        in_valid;
  logic [15:0] a_mat;
  logic [15:0] b_mat;
  logic        ordy [2];
  logic        ir [2];
  logic        ov [2];
  logic        bz [2];
  logic        er [2];
  logic [31:0] cm [2];
  logic [3:0]  ma0 [2];
  logic [3:0]  ma1 [2];
  logic [3:0]  mb0 [2];
  logic [3:0]  mb1 [2];
  logic [7:0]  mc [2];
  logic        corrupt;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] sb0 [$];
  logic [31:0] sb1 [$];

  always #5 clk = ~clk;

  function automatic logic [7:0] udot(input logic [3:0] a0, input logic [3:0] a1,
                                      input logic [3:0] b0, input logic [3:0] b1);
    logic [8:0] s;
    s = {5'b0, a0} * {5'b0, b0} + {5'b0, a1} * {5'b0, b1};
    return s[7:0];
  endfunction

  function automatic logic [31:0] mmul(input logic [15:0] a, input logic [15:0] b);
    logic [31:0] c;
    c = '0;
    for (int i = 0; i < 2; i++) begin
      for (int j = 0; j < 2; j++) begin
        c[(2*i+j)*8 +: 8] = udot(a[(2*i)*4 +: 4], a[(2*i+1)*4 +: 4],
                                 b[j*4 +: 4], b[(2+j)*4 +: 4]);
      end
    end
    return c;
  endfunction

  function automatic int lat_of(input int k);
    return (k == 0) ? 0 : 2;
  endfunction

  // Unit models: combinational for instance 0, two register stages for instance 1.
  logic [7:0] uc0;
  logic [7:0] p1a = 8'h00;
  logic [7:0] p1b = 8'h00;
  assign uc0   = udot(ma0[0], ma1[0], mb0[0], mb1[0]);
  assign mc[0] = corrupt ? 8'h00 : uc0;
  always @(posedge clk) begin
    p1a <= udot(ma0[1], ma1[1], mb0[1], mb1[1]);
    p1b <= p1a;
  end
  assign mc[1] = corrupt ? 8'h00 : p1b;

  matrix_mult_seq #(.DW(4), .CW(8), .PIPE_LAT(0)) u_dut0 (
    .CLK(clk), .RST(rst[0]), .in_valid(in_valid), .in_ready(ir[0]),
    .a_mat(a_mat), .b_mat(b_mat),
    .mm_a0(ma0[0]), .mm_a1(ma1[0]), .mm_b0(mb0[0]), .mm_b1(mb1[0]), .mm_c(mc[0]),
    .out_valid(ov[0]), .out_ready(ordy[0]), .c_mat(cm[0]), .busy(bz[0]), .err(er[0])
  );

  matrix_mult_seq #(.DW(4), .CW(8), .PIPE_LAT(2)) u_dut2 (
    .CLK(clk), .RST(rst[1]), .in_valid(in_valid), .in_ready(ir[1]),
    .a_mat(a_mat), .b_mat(b_mat),
    .mm_a0(ma0[1]), .mm_a1(ma1[1]), .mm_b0(mb0[1]), .mm_b1(mb1[1]), .mm_c(mc[1]),
    .out_valid(ov[1]), .out_ready(ordy[1]), .c_mat(cm[1]), .busy(bz[1]), .err(er[1])
  );

  task automatic wait_idle();
    int t = 0;
    while (!(ir[0] && ir[1]) && t < 64) begin
      @(posedge clk); @(negedge clk);
      t++;
    end
    n_checks++;
    if (!(ir[0] && ir[1])) begin
      n_fail++;
      $display("FAIL idle_wait: in_ready=%0b/%0b required 1/1", ir[0], ir[1]);
    end
  endtask

  // Offers A/B at a negedge, returns at the negedge right after the accept edge.
  task automatic start_txn(input logic [15:0] a, input logic [15:0] b,
                           input logic [31:0] exp, input bit push);
    wait_idle();
    a_mat    = a;
    b_mat    = b;
    in_valid = 1'b1;
    if (push) begin
      sb0.push_back(exp);
      sb1.push_back(exp);
    end
    @(posedge clk); @(negedge clk);
    in_valid = 1'b0;
    for (int k = 0; k < 2; k++) begin
      n_checks++;
      if (bz[k] !== 1'b1 || ir[k] !== 1'b0) begin
        n_fail++;
        $display("FAIL accept[%0d]: busy=%b in_ready=%b required busy=1 in_ready=0", k, bz[k], ir[k]);
      end
      n_checks++;
      if ({ma1[k], ma0[k], mb1[k], mb0[k]} !== {a[7:4], a[3:0], b[11:8], b[3:0]}) begin
        n_fail++;
        $display("FAIL operands_c00[%0d]: got %h required %h", k,
                 {ma1[k], ma0[k], mb1[k], mb0[k]}, {a[7:4], a[3:0], b[11:8], b[3:0]});
      end
    end
  endtask

  task automatic finish_txn(input logic exp_err);
    bit          done [2];
    int          n;
    logic [31:0] exp;
    done[0] = 1'b0;
    done[1] = 1'b0;
    n = 0;
    while (!(done[0] && done[1]) && n <= 20) begin
      for (int k = 0; k < 2; k++) begin
        if (ov[k] && !done[k]) begin
          done[k] = 1'b1;
          n_checks++;
          if (n != 4*(lat_of(k)+1)) begin
            n_fail++;
            $display("FAIL latency[%0d]: out_valid after %0d cycles required %0d", k, n, 4*(lat_of(k)+1));
          end
          if (k == 0) exp = (sb0.size() > 0) ? sb0.pop_front() : 32'hxxxxxxxx;
          else        exp = (sb1.size() > 0) ? sb1.pop_front() : 32'hxxxxxxxx;
          n_checks++;
          if (cm[k] !== exp) begin
            n_fail++;
            $display("FAIL c_mat[%0d]: got %h required %h", k, cm[k], exp);
          end
          n_checks++;
          if (er[k] !== exp_err) begin
            n_fail++;
            $display("FAIL err[%0d]: got %b required %b", k, er[k], exp_err);
          end
        end
      end
      @(posedge clk); @(negedge clk);
      n++;
    end
    for (int k = 0; k < 2; k++) begin
      n_checks++;
      if (!done[k]) begin
        n_fail++;
        $display("FAIL timeout[%0d]: out_valid=0 required 1 within 20 cycles", k);
      end
    end
  endtask

  task automatic test_reset();
    rst[0] = 1'b1; rst[1] = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      n_checks++;
      if ({ir[k], ov[k], bz[k], er[k]} !== 4'b0 || cm[k] !== 32'h0 ||
          {ma0[k], ma1[k], mb0[k], mb1[k]} !== 16'h0) begin
        n_fail++;
        $display("FAIL reset_state[%0d]: rdy/vld/busy/err=%b%b%b%b c=%h ops=%h required all 0",
                 k, ir[k], ov[k], bz[k], er[k], cm[k], {ma0[k], ma1[k], mb0[k], mb1[k]});
      end
    end
    rst[0] = 1'b0; rst[1] = 1'b0;
    #1;
    for (int k = 0; k < 2; k++) begin
      n_checks++;
      if (ir[k] !== 1'b1) begin
        n_fail++;
        $display("FAIL reset_release_ready[%0d]: in_ready=%b required 1", k, ir[k]);
      end
    end
  endtask

  task automatic test_identity();
    start_txn(16'h1001, 16'h4321, 32'h04030201, 1'b1);
    finish_txn(1'b0);
  endtask

  task automatic test_mixed();
    start_txn(16'h1223, 16'h2211, 32'h04040707, 1'b1);
    finish_txn(1'b0);
  endtask

  task automatic test_all15();
    start_txn(16'hFFFF, 16'hFFFF, 32'hC2C2C2C2, 1'b1);
    finish_txn(1'b0);
  endtask

  task automatic test_backpressure();
    logic [31:0] exp;
    ordy[0] = 1'b0; ordy[1] = 1'b0;
    start_txn(16'h1223, 16'h2211, 32'h04040707, 1'b1);
    for (int t = 0; t < 20 && !(ov[0] && ov[1]); t++) begin
      @(posedge clk); @(negedge clk);
    end
    for (int c = 0; c < 10; c++) begin
      for (int k = 0; k < 2; k++) begin
        n_checks++;
        if (ov[k] !== 1'b1 || ir[k] !== 1'b0 || cm[k] !== 32'h04040707) begin
          n_fail++;
          $display("FAIL hold[%0d] cycle %0d: vld=%b rdy=%b c=%h required vld=1 rdy=0 c=04040707",
                   k, c, ov[k], ir[k], cm[k]);
        end
      end
      in_valid = c[0];
      a_mat    = 16'($urandom);
      b_mat    = 16'($urandom);
      @(posedge clk); @(negedge clk);
    end
    for (int k = 0; k < 2; k++) begin
      if (k == 0) exp = (sb0.size() > 0) ? sb0.pop_front() : 32'hxxxxxxxx;
      else        exp = (sb1.size() > 0) ? sb1.pop_front() : 32'hxxxxxxxx;
      n_checks++;
      if (cm[k] !== exp || ov[k] !== 1'b1) begin
        n_fail++;
        $display("FAIL hold_release[%0d]: vld=%b c=%h required vld=1 c=%h", k, ov[k], cm[k], exp);
      end
    end
    a_mat = 16'h1001; b_mat = 16'hFEDC; in_valid = 1'b1;
    ordy[0] = 1'b1; ordy[1] = 1'b1;
    @(posedge clk); @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      n_checks++;
      if (ov[k] !== 1'b0 || ir[k] !== 1'b1) begin
        n_fail++;
        $display("FAIL handshake[%0d]: vld=%b rdy=%b required vld=0 rdy=1", k, ov[k], ir[k]);
      end
    end
    sb0.push_back(32'h0F0E0D0C);
    sb1.push_back(32'h0F0E0D0C);
    @(posedge clk); @(negedge clk);
    in_valid = 1'b0;
    for (int k = 0; k < 2; k++) begin
      n_checks++;
      if (bz[k] !== 1'b1) begin
        n_fail++;
        $display("FAIL reaccept[%0d]: busy=%b required 1", k, bz[k]);
      end
    end
    finish_txn(1'b0);
  endtask

  task automatic test_abort();
    start_txn(16'h1223, 16'h2211, 32'h0, 1'b0);
    for (int n = 0; n <= 16; n++) begin
      for (int k = 0; k < 2; k++) begin
        if (n == 2*(lat_of(k)+1)) begin
          n_checks++;
          if (bz[k] !== 1'b1 || cm[k][15:0] !== 16'h0707) begin
            n_fail++;
            $display("FAIL abort_pre[%0d]: busy=%b c=%h required busy=1 c[15:0]=0707", k, bz[k], cm[k]);
          end
          rst[k] = 1'b1;
        end else if (n == 2*(lat_of(k)+1) + 1) begin
          rst[k] = 1'b0;
          n_checks++;
          if ({ov[k], bz[k], er[k]} !== 3'b0 || cm[k] !== 32'h0 ||
              {ma0[k], ma1[k], mb0[k], mb1[k]} !== 16'h0) begin
            n_fail++;
            $display("FAIL abort_clear[%0d]: vld/busy/err=%b%b%b c=%h ops=%h required all 0",
                     k, ov[k], bz[k], er[k], cm[k], {ma0[k], ma1[k], mb0[k], mb1[k]});
          end
        end
        n_checks++;
        if (ov[k] !== 1'b0) begin
          n_fail++;
          $display("FAIL abort_no_valid[%0d] cycle %0d: out_valid=%b required 0", k, n, ov[k]);
        end
      end
      @(posedge clk); @(negedge clk);
    end
    start_txn(16'h3142, 16'h2413, mmul(16'h3142, 16'h2413), 1'b1);
    finish_txn(1'b0);
  endtask

  task automatic test_back_to_back();
    logic [15:0] a;
    logic [15:0] b;
    for (int t = 0; t < 4; t++) begin
      a = 16'($urandom);
      b = 16'($urandom);
      start_txn(a, b, mmul(a, b), 1'b1);
      finish_txn(1'b0);
    end
  endtask

  task automatic test_check();
    logic sticky;
`ifdef MATRIX_MULT_SEQ_CHECK_EN
    sticky = 1'b1;
`else
    sticky = 1'b0;
`endif
    corrupt = 1'b1;
    start_txn(16'h1223, 16'h2211, 32'h00000000, 1'b1);
    finish_txn(sticky);
    corrupt = 1'b0;
    start_txn(16'h1001, 16'h4321, 32'h04030201, 1'b1);
    finish_txn(sticky);
    rst[0] = 1'b1; rst[1] = 1'b1;
    @(posedge clk); @(negedge clk);
    rst[0] = 1'b0; rst[1] = 1'b0;
    for (int k = 0; k < 2; k++) begin
      n_checks++;
      if (er[k] !== 1'b0) begin
        n_fail++;
        $display("FAIL err_clear[%0d]: err=%b required 0", k, er[k]);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst[0]   = 1'b1;
    rst[1]   = 1'b1;
    in_valid = 1'b0;
    a_mat    = '0;
    b_mat    = '0;
    ordy[0]  = 1'b1;
    ordy[1]  = 1'b1;
    corrupt  = 1'b0;
    @(negedge clk);
    test_reset();
    test_identity();
    test_mixed();
    test_all15();
    test_backpressure();
    test_abort();
    test_back_to_back();
    test_check();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
